// File: rtl/cordic_arb_pkg.sv
// Shared types and helpers for the round-robin CORDIC core arbiter.
package cordic_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 16;
    localparam int NREQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } cordic_arb_state_t;

    // First valid index after 'last', wrapping at nreq; returns 'last' when nothing is valid.
    function automatic logic [2:0] rr_next(input logic [NREQ_MAX-1:0] valid,
                                           input logic [2:0]          last,
                                           input int                  nreq);
        logic       found;
        logic [2:0] cand;
        rr_next = last;
        found   = 1'b0;
        for (int k = 1; k <= NREQ_MAX; k++) begin
            cand = 3'((int'(last) + k) % nreq);
            if ((k <= nreq) && !found && valid[cand]) begin
                rr_next = cand;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/cordic_rr_pick.sv
// Combinational round-robin picker: valid vector and last winner in, one-hot grant,
// winner index and any-valid flag out.
module cordic_rr_pick
    import cordic_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic [NREQ_MAX-1:0] w_valid_ext;

    always_comb begin
        w_valid_ext             = '0;
        w_valid_ext[NREQ-1:0]   = i_valid;
    end

    assign o_idx = IW'(rr_next(w_valid_ext, 3'(i_last), NREQ));
    assign o_any = |i_valid;

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_grant[i] = o_any && (o_idx == IW'(i));
        end
    end

endmodule

// File: rtl/cordic_core_arbiter.sv
// Shares one iterative CORDIC core among NREQ requesters with round-robin fairness.
// Optional WAIT watchdog is built when CORDIC_ARB_TIMEOUT_EN is defined.
module cordic_core_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int NREQ           = NREQ_DEF,
    parameter int DW             = DW_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*DW-1:0]    req_angle,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic signed [DW-1:0]  rsp_cos,
    output logic signed [DW-1:0]  rsp_sin,
    output logic                  rsp_err,
    output logic                  core_start,
    output logic signed [DW-1:0]  core_angle,
    input  logic                  core_done,
    input  logic signed [DW-1:0]  core_cos,
    input  logic signed [DW-1:0]  core_sin,
    output logic                  busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    cordic_arb_state_t    r_state, w_next;
    logic [IW-1:0]        r_last, r_gidx, w_pick_idx;
    logic [NREQ-1:0]      w_pick_grant, r_rsp_valid, w_rsp_onehot;
    logic                 w_pick_any, w_accept, w_done, w_timeout;
    logic                 r_core_start, r_busy;
    logic signed [DW-1:0] r_core_angle, r_cos, r_sin;

    cordic_rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .i_valid (req_valid),
        .i_last  (r_last),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_wcnt;
    logic          r_err;

    // A done arriving on the expiry cycle takes priority over the timeout.
    assign w_timeout = (r_state == WAIT) && !core_done && (r_wcnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_wcnt <= '0;
        end else if ((r_state == WAIT) && (w_next == WAIT)) begin
            r_wcnt <= r_wcnt + CW'(1);
        end else begin
            r_wcnt <= '0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_err <= 1'b0;
        end else if (w_accept || w_done) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign rsp_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_pick_any) w_next = START;
            START:   w_next = WAIT;
            WAIT:    if (core_done || w_timeout) w_next = RESP;
            RESP:    if (rsp_ready[r_gidx]) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // req_ready is the only combinational output; it is forced low while reset is held.
    always_comb begin
        req_ready    = '0;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_rsp_onehot = '0;
        if ((r_state == IDLE) && ARESETN) begin
            req_ready = w_pick_grant;
            w_accept  = w_pick_any;
        end
        if (r_state == WAIT) begin
            w_done = core_done;
        end
        for (int i = 0; i < NREQ; i++) begin
            w_rsp_onehot[i] = (w_next == RESP) && (r_gidx == IW'(i));
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_last       <= IW'(NREQ - 1);
            r_gidx       <= '0;
            r_core_start <= 1'b0;
            r_busy       <= 1'b0;
            r_rsp_valid  <= '0;
        end else begin
            r_core_start <= (w_next == START);
            r_busy       <= (w_next != IDLE);
            r_rsp_valid  <= w_rsp_onehot;
            if (w_accept) begin
                r_last <= w_pick_idx;
                r_gidx <= w_pick_idx;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_core_angle <= '0;
            r_cos        <= '0;
            r_sin        <= '0;
        end else begin
            if (w_accept) begin
                r_core_angle <= req_angle[w_pick_idx*DW +: DW];
            end
            if (w_done) begin
                r_cos <= core_cos;
                r_sin <= core_sin;
            end else if (w_timeout) begin
                r_cos <= '0;
                r_sin <= '0;
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_cos    = r_cos;
    assign rsp_sin    = r_sin;
    assign core_start = r_core_start;
    assign core_angle = r_core_angle;
    assign busy       = r_busy;

endmodule

// File: tb/tb_cordic_core_arbiter.sv
// Directed bench for cordic_core_arbiter with a fixed-latency core model
// (cos = angle ^ 0x5A5A, sin = angle + 0x0101).
module tb_cordic_core_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int TO   = 64;

    logic               ACLK = 1'b0;
    logic               ARESETN = 1'b0;
    logic [NREQ-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*DW-1:0] req_angle;
    logic [DW-1:0]      rsp_cos, rsp_sin, core_angle, core_cos, core_sin;
    logic               rsp_err, core_start, core_done, busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int lc    = 16;
    int pend  = 0;
    int inj_req = 0;
    int inj_ack = 0;
    logic [DW-1:0] m_ang;

    cordic_core_arbiter #(
        .NREQ(NREQ), .DW(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_angle(req_angle),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_cos(rsp_cos), .rsp_sin(rsp_sin), .rsp_err(rsp_err),
        .core_start(core_start), .core_angle(core_angle),
        .core_done(core_done), .core_cos(core_cos), .core_sin(core_sin),
        .busy(busy)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    // Core model: done lc cycles after the start pulse; lc == 0 means never finish.
    initial begin
        core_done = 1'b0;
        core_cos  = '0;
        core_sin  = '0;
        m_ang     = '0;
        forever begin
            @(negedge ACLK);
            core_done = 1'b0;
            if (inj_req != inj_ack) begin
                inj_ack   = inj_req;
                core_done = 1'b1;
                core_cos  = 16'hDEAD;
                core_sin  = 16'hBEEF;
            end else if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    core_done = 1'b1;
                    core_cos  = m_ang ^ 16'h5A5A;
                    core_sin  = m_ang + 16'h0101;
                end
            end
            if (core_start && (lc > 0)) begin
                pend  = lc;
                m_ang = core_angle;
            end
        end
    end

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_angle(input int i, input logic [DW-1:0] a);
        req_angle[i*DW +: DW] = a;
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge ACLK);
            if (rsp_valid != '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk_eq(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge ACLK);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk_eq(tag, 64'(ok), 64'd1);
    endtask

    task automatic do_reset();
        ARESETN   = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ta, tprev, ng, bad;
        req_valid = '0;
        rsp_ready = '0;
        req_angle = '0;

        // Reset state
        repeat (2) @(negedge ACLK);
        chk_eq("rst_req_ready", req_ready, 0);
        chk_eq("rst_rsp_valid", rsp_valid, 0);
        chk_eq("rst_rsp_cos", rsp_cos, 0);
        chk_eq("rst_rsp_sin", rsp_sin, 0);
        chk_eq("rst_rsp_err", rsp_err, 0);
        chk_eq("rst_core_start", core_start, 0);
        chk_eq("rst_core_angle", core_angle, 0);
        chk_eq("rst_busy", busy, 0);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // Single requester, Lc = 16
        lc = 16;
        set_angle(2, 16'h2000);
        req_valid = 4'b0100;
        #1;
        chk_eq("single_ready", req_ready, 4'b0100);
        ta = cyc;
        @(negedge ACLK);
        req_valid = '0;
        chk_eq("single_start", core_start, 1);
        chk_eq("single_core_angle", core_angle, 16'h2000);
        chk_eq("single_busy", busy, 1);
        @(negedge ACLK);
        chk_eq("single_start_pulse", core_start, 0);
        wait_rsp("single_rsp_seen", 100);
        chk_eq("single_latency", cyc - ta, 18);
        chk_eq("single_rsp_valid", rsp_valid, 4'b0100);
        chk_eq("single_cos", rsp_cos, 16'h7A5A);
        chk_eq("single_sin", rsp_sin, 16'h2101);
        chk_eq("single_err", rsp_err, 0);
        rsp_ready = 4'b0100;
        @(negedge ACLK);
        rsp_ready = '0;
        chk_eq("single_rsp_drop", rsp_valid, 0);
        chk_eq("single_idle", busy, 0);

        // Round-robin, all valid, Lc = 4 -> period 7
        do_reset();
        lc = 4;
        for (int i = 0; i < NREQ; i++) set_angle(i, 16'h1000 + 16'(i * 256));
        rsp_ready = '1;
        req_valid = '1;
        ng = 0;
        tprev = 0;
        #1;
        for (int k = 0; (k < 200) && (ng < 5); k++) begin
            if (req_ready != '0) begin
                chk_eq($sformatf("rr_grant%0d", ng), req_ready, 64'd1 << (ng % 4));
                if (ng > 0) chk_eq("rr_period", cyc - tprev, 7);
                tprev = cyc;
                ng++;
            end
            @(negedge ACLK);
            #1;
        end
        chk_eq("rr_count", ng, 5);
        req_valid = '0;
        wait_idle("rr_idle");
        rsp_ready = '0;

        // Backpressure on requester 1; other ready bits high and must be ignored
        lc = 3;
        set_angle(1, 16'h4321);
        rsp_ready = 4'b1101;
        req_valid = 4'b0010;
        #1;
        chk_eq("bp_ready", req_ready, 4'b0010);
        @(negedge ACLK);
        req_valid = 4'b1000;
        wait_rsp("bp_rsp_seen", 50);
        for (int k = 0; k < 10; k++) begin
            if (k == 4) inj_req = inj_req + 1;
            chk_eq("bp_rsp_valid", rsp_valid, 4'b0010);
            chk_eq("bp_cos", rsp_cos, 16'h197B);
            chk_eq("bp_sin", rsp_sin, 16'h4422);
            chk_eq("bp_no_accept", req_ready, 0);
            @(negedge ACLK);
        end
        rsp_ready = '1;
        @(negedge ACLK);
        chk_eq("bp_rsp_drop", rsp_valid, 0);
        chk_eq("bp_next_grant", req_ready, 4'b1000);
        @(negedge ACLK);
        req_valid = '0;
        wait_idle("bp_idle");
        rsp_ready = '0;

        // Reset 5 cycles after START, then a stray done lands in IDLE
        lc = 20;
        set_angle(2, 16'h0ABC);
        req_valid = 4'b0100;
        #1;
        chk_eq("mw_ready", req_ready, 4'b0100);
        ta = cyc;
        @(negedge ACLK);
        req_valid = '0;
        repeat (5) @(negedge ACLK);
        ARESETN = 1'b0;
        #1;
        chk_eq("mw_busy", busy, 0);
        chk_eq("mw_core_angle", core_angle, 0);
        chk_eq("mw_core_start", core_start, 0);
        chk_eq("mw_rsp_valid", rsp_valid, 0);
        chk_eq("mw_rsp_cos", rsp_cos, 0);
        chk_eq("mw_req_ready", req_ready, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        bad = 0;
        for (int k = 0; (k < 40) && (cyc < ta + 24); k++) begin
            @(negedge ACLK);
            if (busy || (rsp_valid != '0)) bad++;
        end
        chk_eq("mw_stray_idle", bad, 0);
        rsp_ready = '1;
        req_valid = '1;
        #1;
        chk_eq("mw_first_grant", req_ready, 4'b0001);
        @(negedge ACLK);
        req_valid = '0;
        wait_idle("mw_idle");
        rsp_ready = '0;

`ifdef CORDIC_ARB_TIMEOUT_EN
        // Core never finishes: watchdog response after 64 WAIT cycles
        lc = 0;
        req_valid = 4'b0010;
        #1;
        chk_eq("to_ready", req_ready, 4'b0010);
        ta = cyc;
        @(negedge ACLK);
        req_valid = '0;
        wait_rsp("to_rsp_seen", 100);
        chk_eq("to_latency", cyc - ta, 66);
        chk_eq("to_err", rsp_err, 1);
        chk_eq("to_cos", rsp_cos, 0);
        chk_eq("to_sin", rsp_sin, 0);
        rsp_ready = 4'b0010;
        @(negedge ACLK);
        rsp_ready = '0;

        // Done on the expiry cycle wins
        lc = 64;
        req_valid = 4'b0010;
        #1;
        chk_eq("tx_ready", req_ready, 4'b0010);
        ta = cyc;
        @(negedge ACLK);
        req_valid = '0;
        wait_rsp("tx_rsp_seen", 100);
        chk_eq("tx_latency", cyc - ta, 66);
        chk_eq("tx_err", rsp_err, 0);
        chk_eq("tx_cos", rsp_cos, 16'h197B);
        chk_eq("tx_sin", rsp_sin, 16'h4422);
        rsp_ready = 4'b0010;
        @(negedge ACLK);
        rsp_ready = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cordic_core_arbiter.md
# cordic_core_arbiter

Shares one iterative CORDIC core among `NREQ` requesters with round-robin fairness. Each requester issues an angle with a valid/ready handshake. The arbiter launches the core and routes the cos/sin result back to the winner over a per-requester valid/ready response channel. It sits between the AXI-lite register front-ends (or other hardware clients) and the single CORDIC datapath in the IP.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `DW`, 16: angle and result width, signed two's complement.
- `TIMEOUT_CYCLES`, 64: watchdog limit in WAIT (used only with the macro).
- `ACLK  in  1`: clock. One clock domain, rising edge.
- `ARESETN  in  1`: reset, asynchronous assert, active-low.
- `req_valid  in  NREQ`: per-requester request valid.
- `req_ready  out  NREQ`: one-hot accept.
- `req_angle  in  NREQ*DW`: flattened angles; requester i uses slice [i*DW +: DW].
- `rsp_valid  out  NREQ`: one-hot result valid.
- `rsp_ready  in  NREQ`: per-requester result accept.
- `rsp_cos`, `rsp_sin  out  DW`: shared result bus, valid for the asserted `rsp_valid` bit.
- `rsp_err  out  1`: qualifies the current response as a timeout.
- `core_start  out  1`: one-cycle launch pulse.
- `core_angle  out  DW`: registered angle, held stable from START until the next accept.
- `core_done  in  1`: one-cycle completion pulse.
- `core_cos`, `core_sin  in  DW`: core results, sampled on `core_done`.
- `busy  out  1`: high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, START, WAIT, RESP.
- **IDLE:** if any `req_valid` is high, pick winner g.
  - Search starts at `last_grant+1` and wraps modulo NREQ.
  - `req_ready[g]` is driven combinationally in this cycle, so the handshake completes this cycle.
  - Latch `req_angle[g]` into `core_angle`, latch g, set `last_grant`=g, go to START.
- **START:** `core_start`=1 for exactly one cycle, then go to WAIT.
- **WAIT:** on `core_done`, capture `core_cos`/`core_sin`, clear `rsp_err`, go to RESP.
- **RESP:** hold `rsp_valid[g]` and the data stable until `rsp_ready[g]`, then go to IDLE.
  - Other `rsp_ready` bits are ignored.
- **Core-done filtering:** `core_done` is ignored outside WAIT. A `core_done` in the same cycle as START is also ignored, because the core cannot finish in 0 cycles.
- **Held requests:** requests that arrive while busy are not dropped. They stay pending on the requester side, since `req_ready` stays 0.
- **Fairness:** a requester that holds `req_valid` continuously is served within NREQ transactions.
- **Reset values:**
  - All outputs are 0.
  - State is IDLE.
  - `last_grant`=NREQ-1, so requester 0 wins first.
  - Result registers are 0.
- **Reset mid-operation:** the arbiter returns to IDLE immediately and any in-flight response is lost. The core is not aborted; a later stray `core_done` is ignored in IDLE.
- **Widths:** results pass through unmodified at DW bits. There is no rounding or saturation in this block.

## Timing
- Accept in cycle t; `core_start` in t+1; core latency Lc ≥ 1 gives `core_done` in t+1+Lc.
- `rsp_valid` rises in t+2+Lc.
- With `rsp_ready` held high, the next accept is at t+3+Lc, so the minimum issue period is Lc+3 cycles.
- `req_ready` depends combinationally on `req_valid` and state only. Requesters must not make `req_valid` depend on `req_ready`.
- All other outputs are registered.

## Configuration
- **`CORDIC_ARB_TIMEOUT_EN` defined:** a WAIT cycle counter counts from entry to WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `core_done`, go to RESP with `rsp_err`=1 and `rsp_cos`=`rsp_sin`=0.
  - The counter clears on leaving WAIT.
  - A `core_done` in the same cycle as expiry wins: normal response, `rsp_err`=0.
- **Macro undefined:** no counter is built, `rsp_err` is tied 0, and WAIT waits indefinitely.

## Structure
- `cordic_arb_pkg` holds:
  - the state enum type `cordic_arb_state_t` (IDLE, START, WAIT, RESP);
  - the `NREQ`/`DW` default localparams;
  - a function `rr_next(valid, last)` returning the winner index.
- One sub-module, `cordic_rr_pick`: a combinational round-robin picker (valid vector + last index → one-hot grant + index + any).
- The FSM, data registers and watchdog stay in `cordic_core_arbiter`.

## Test plan
- **Single requester:** after reset, `req_valid[2]`=1, angle 0x2000, core model Lc=16 → `req_ready[2]` in the same cycle; `core_start` one cycle later with `core_angle`=0x2000; `rsp_valid`=4'b0100 exactly 18 cycles after accept with the model's cos/sin.
- **Round-robin:** all four requesters valid continuously, `rsp_ready` held high → grant order 0,1,2,3,0; each grant Lc+3 cycles apart.
- **Backpressure:** `rsp_ready[g]` held low for 10 cycles → `rsp_valid` and data stable for all 10 cycles; no new `req_ready` until the handshake; a `core_done` pulse during RESP has no effect.
- **Reset mid-WAIT:** deassert `ARESETN` 5 cycles after START → all outputs 0 asynchronously; after release the next grant goes to requester 0; a late `core_done` in IDLE is ignored.
- **Timeout (`CORDIC_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=64):** core model never asserts done → RESP entered with `rsp_err`=1 and zero data. With done on the expiry cycle → `rsp_err`=0 and real data.
